// File: rtl/mmu_sequencer.sv
// Job sequencer for an N x N systolic matrix unit: buffers N operand beats,
// drives clear/feed/wait/shift phases, captures result rows and streams them out.
module mmu_sequencer #(
    parameter int VAR_SIZE = 8,
    parameter int ACC_SIZE = 32,
    parameter int MMU_SIZE = 10,
    localparam int IDX_W = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [VAR_SIZE*MMU_SIZE-1:0] a_col,
    input  logic [VAR_SIZE*MMU_SIZE-1:0] b_row,
    output logic [VAR_SIZE*MMU_SIZE-1:0] mmu_a,
    output logic [VAR_SIZE*MMU_SIZE-1:0] mmu_b,
    output logic                         mmu_clear,
    output logic                         mmu_shift,
    input  logic [ACC_SIZE*MMU_SIZE-1:0] mmu_c,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_SIZE*MMU_SIZE-1:0] c_row,
    output logic [IDX_W-1:0]             c_idx,
    output logic                         c_last,
    output logic                         busy
);

    // WAIT counts up to N inclusive, so the counter needs one extra value
    localparam int CNT_W = $clog2(MMU_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MMU_SIZE - 1);
    localparam logic [CNT_W-1:0] NCNT = CNT_W'(MMU_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_FEED, S_WAIT, S_SHIFT, S_CAPTURE, S_OUT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx, cap_idx;
    logic             beat_acc;

    logic [VAR_SIZE*MMU_SIZE-1:0] a_buf_q [MMU_SIZE];
    logic [VAR_SIZE*MMU_SIZE-1:0] b_buf_q [MMU_SIZE];
    logic [ACC_SIZE*MMU_SIZE-1:0] res_q   [MMU_SIZE];

    assign idx      = cnt_q[IDX_W-1:0];
    assign cap_idx  = IDX_W'(MMU_SIZE - 1) - idx;
    assign beat_acc = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (MMU_SIZE == 1) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_LOAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == NCNT) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                if (cnt_q == LAST) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mmu_a     = '0;
        mmu_b     = '0;
        mmu_clear = 1'b0;
        mmu_shift = 1'b0;
        out_valid = 1'b0;
        c_row     = '0;
        c_idx     = '0;
        c_last    = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE, S_LOAD: in_ready = !rst;
            S_CLEAR:        mmu_clear = 1'b1;
            S_FEED: begin
                mmu_a = a_buf_q[idx];
                mmu_b = b_buf_q[idx];
            end
            S_SHIFT:        mmu_shift = 1'b1;
            S_OUT: begin
                out_valid = 1'b1;
                c_row     = res_q[idx];
                c_idx     = idx;
                c_last    = (cnt_q == LAST);
            end
            default: ;
        endcase
    end

    // Data buffers carry no reset; OUT is only reachable after a full CAPTURE pass
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            a_buf_q[idx] <= a_col;
            b_buf_q[idx] <= b_row;
        end
        if (state_q == S_CAPTURE) begin
            res_q[cap_idx] <= mmu_c;
        end
    end

endmodule
